// File: rtl/fir_coeff_sequencer_if.sv
// Signal bundle between the sample/host side and the adaptive FIR input port,
// as seen by the coefficient sequencer.
interface fir_coeff_sequencer_if #(
    parameter int DATA_W     = 8,
    parameter int NUM_COEFFS = 3,
    parameter int ADDR_W     = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     coeff_wr_en;
    logic        [ADDR_W-1:0] coeff_wr_addr;
    logic signed [DATA_W-1:0] coeff_wr_data;
    logic                     load_req;
    logic signed [DATA_W-1:0] x_n;
    logic                     s_axis_fir_tvalid;
    logic                     s_set_coeffs;
    logic                     busy;
    logic                     load_done;
    logic                     overflow;

    modport master (
        output sample_in, sample_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data, load_req,
        input  x_n, s_axis_fir_tvalid, s_set_coeffs, busy, load_done, overflow
    );

    modport slave (
        input  sample_in, sample_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data, load_req,
        output x_n, s_axis_fir_tvalid, s_set_coeffs, busy, load_done, overflow
    );
endinterface

// File: rtl/fir_coeff_sequencer.sv
// Feeds an adaptive FIR with samples, interleaving coefficient-load bursts from a
// shadow bank; samples arriving during a burst are buffered and replayed in order.
module fir_coeff_sequencer #(
    parameter int DATA_W     = 8,
    parameter int NUM_COEFFS = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_coeff_sequencer_if.slave bus
);
    localparam int ADDR_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEFFS - 1);

    typedef enum logic {ST_STREAM = 1'b0, ST_LOAD = 1'b1} state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_shadow [NUM_COEFFS];
    logic signed [DATA_W-1:0] r_snap   [NUM_COEFFS];
    logic signed [DATA_W-1:0] r_fifo   [FIFO_DEPTH];
    logic        [ADDR_W-1:0] r_cnt;
    logic         [PTR_W-1:0] r_wr_ptr;
    logic         [PTR_W-1:0] r_rd_ptr;
    logic                     r_pending;
    logic                     r_last_coeff;
    logic signed [DATA_W-1:0] r_x_n;
    logic                     r_tvalid;
    logic                     r_set_coeffs;
    logic                     r_busy;
    logic                     r_load_done;
    logic                     r_overflow;

    logic signed [DATA_W-1:0] w_shadow_nxt [NUM_COEFFS];
    logic                     w_empty;
    logic                     w_full;
    logic                     w_start;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;

    // A write in the same cycle as a load request must land in the snapshot.
    // NOTE: the whole array gets a default before the conditional update so no latch is inferred.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (bus.coeff_wr_en && (int'(bus.coeff_wr_addr) < NUM_COEFFS))
            w_shadow_nxt[bus.coeff_wr_addr] = bus.coeff_wr_data;
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
    assign w_start = bus.load_req || r_pending;
    assign w_pop   = (r_state == ST_STREAM) && !w_empty;
    assign w_push  = bus.sample_valid && ((r_state == ST_STREAM) ? !w_empty : !w_full);
    assign w_drop  = bus.sample_valid && (r_state == ST_LOAD) && w_full;

    // NOTE: the sample buffer has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[PTR_W-2:0]] <= bus.sample_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_shadow <= '{default: '0};
        else
            r_shadow <= w_shadow_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_STREAM;
            r_snap       <= '{default: '0};
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pending    <= 1'b0;
            r_last_coeff <= 1'b0;
            r_x_n        <= '0;
            r_tvalid     <= 1'b0;
            r_set_coeffs <= 1'b0;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_load_done  <= r_last_coeff;
            r_last_coeff <= 1'b0;
            r_busy       <= (r_state == ST_LOAD) || r_pending;
            if (w_push) r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;

            case (r_state)
                ST_STREAM: begin
                    r_set_coeffs <= 1'b0;
                    if (!w_empty) begin
                        r_x_n    <= r_fifo[r_rd_ptr[PTR_W-2:0]];
                        r_tvalid <= 1'b1;
                    end else if (bus.sample_valid) begin
                        r_x_n    <= bus.sample_in;
                        r_tvalid <= 1'b1;
                    end else begin
                        r_tvalid <= 1'b0;
                    end
                    if (w_start) begin
                        r_state   <= ST_LOAD;
                        r_snap    <= w_shadow_nxt;
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_tvalid     <= 1'b0;
                    r_set_coeffs <= 1'b1;
                    r_x_n        <= r_snap[r_cnt];
                    if (r_cnt == LAST_IDX) begin
                        r_last_coeff <= 1'b1;
                        // A held request chains straight into the next burst.
                        if (w_start) begin
                            r_snap    <= w_shadow_nxt;
                            r_cnt     <= '0;
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (bus.load_req) r_pending <= 1'b1;
                    end
                end
                default: r_state <= ST_STREAM;
            endcase
        end
    end

    assign bus.x_n               = r_x_n;
    assign bus.s_axis_fir_tvalid = r_tvalid;
    assign bus.s_set_coeffs      = r_set_coeffs;
    assign bus.busy              = r_busy;
    assign bus.load_done         = r_load_done;
    assign bus.overflow          = r_overflow;
endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Testbench for fir_coeff_sequencer: queue-based reference of the visible
// output stream, directed scenarios followed by randomized traffic.
module tb_fir_coeff_sequencer;
    localparam int DATA_W     = 8;
    localparam int NUM_COEFFS = 3;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_coeff_sequencer_if #(.DATA_W(DATA_W), .NUM_COEFFS(NUM_COEFFS)) bus ();

    fir_coeff_sequencer #(
        .DATA_W(DATA_W), .NUM_COEFFS(NUM_COEFFS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: shadow bank, remaining coefficients of the burst in flight, sample backlog.
    logic [7:0] m_shadow [NUM_COEFFS];
    logic [7:0] m_coeffs [$];
    logic [7:0] m_fifo   [$];
    bit         m_pending;
    bit         m_final_prev;
    logic [7:0] e_x;
    logic       e_tv, e_set, e_busy, e_done, e_ovf;

    function automatic logic [12:0] obs();
        return {bus.x_n, bus.s_axis_fir_tvalid, bus.s_set_coeffs, bus.busy, bus.load_done, bus.overflow};
    endfunction

    function automatic logic [12:0] expv();
        return {e_x, e_tv, e_set, e_busy, e_done, e_ovf};
    endfunction

    task automatic model_reset();
        foreach (m_shadow[i]) m_shadow[i] = '0;
        m_coeffs.delete();
        m_fifo.delete();
        m_pending = 0; m_final_prev = 0;
        e_x = '0; e_tv = 0; e_set = 0; e_busy = 0; e_done = 0; e_ovf = 0;
    endtask

    task automatic model_step(input bit valid, input logic [7:0] s, input bit wr,
                              input logic [1:0] addr, input logic [7:0] data, input bit ld);
        bit in_load;
        in_load      = (m_coeffs.size() > 0);
        e_busy       = in_load || m_pending;
        e_done       = m_final_prev;
        m_final_prev = 0;
        if (wr && addr < NUM_COEFFS) m_shadow[addr] = data;
        if (in_load) begin
            e_x = m_coeffs.pop_front(); e_set = 1; e_tv = 0;
            if (valid) begin
                if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(s);
                else e_ovf = 1;
            end
            if (m_coeffs.size() == 0) begin
                m_final_prev = 1;
                if (m_pending || ld) begin
                    for (int i = 0; i < NUM_COEFFS; i++) m_coeffs.push_back(m_shadow[i]);
                    m_pending = 0;
                end
            end else if (ld) begin
                m_pending = 1;
            end
        end else begin
            e_set = 0;
            if (m_fifo.size() > 0) begin
                e_x = m_fifo.pop_front(); e_tv = 1;
                if (valid) m_fifo.push_back(s);
            end else if (valid) begin
                e_x = s; e_tv = 1;
            end else begin
                e_tv = 0;
            end
            if (ld || m_pending) begin
                for (int i = 0; i < NUM_COEFFS; i++) m_coeffs.push_back(m_shadow[i]);
                m_pending = 0;
            end
        end
    endtask

    task automatic drive_cycle(input bit valid, input logic [7:0] s, input bit wr,
                               input logic [1:0] addr, input logic [7:0] data, input bit ld);
        bus.sample_valid  = valid;
        bus.sample_in     = s;
        bus.coeff_wr_en   = wr;
        bus.coeff_wr_addr = addr;
        bus.coeff_wr_data = data;
        bus.load_req      = ld;
        @(posedge clk);
        model_step(valid, s, wr, addr, data, ld);
        #1;
    endtask

    task automatic test_reset();
        bus.sample_valid = 0; bus.sample_in = '0; bus.coeff_wr_en = 0;
        bus.coeff_wr_addr = '0; bus.coeff_wr_data = '0; bus.load_req = 0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 13'h0) $display("FAIL reset: outputs got %h expected %h", obs(), 13'h0);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(i < 3, 8'(i + 1), 0, 2'd0, 8'h00, 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL stream[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_idle_load();
        logic [7:0] wr_vals [3] = '{8'h07, 8'hFB, 8'h1B};
        int n_set = 0, n_done = 0;
        for (int i = 0; i < 3; i++) drive_cycle(0, 8'h00, 1, 2'(i), wr_vals[i], 0);
        for (int i = 0; i < 7; i++) begin
            drive_cycle(0, 8'h00, 0, 2'd0, 8'h00, i == 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL idle_load[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
            n_set  += int'(bus.s_set_coeffs);
            n_done += int'(bus.load_done);
        end
        n_checks++;
        if (n_set !== 3 || n_done !== 1)
            $display("FAIL idle_load_counts: got set=%0d done=%0d expected set=3 done=1", n_set, n_done);
        else n_pass++;
    endtask

    task automatic test_load_during_stream();
        int seen[$];
        int gaps = 0;
        for (int i = 0; i < 24; i++) begin
            drive_cycle(i < 20, 8'(10 + i), 0, 2'd0, 8'h00, i == 2);
            n_checks++;
            if (obs() !== expv()) $display("FAIL load_stream[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
            if (bus.s_axis_fir_tvalid) seen.push_back(int'(bus.x_n));
        end
        foreach (seen[i]) if (seen[i] != 10 + i) gaps++;
        n_checks++;
        if (seen.size() !== 20 || gaps !== 0)
            $display("FAIL load_stream_order: got %0d samples %0d out of order, expected 20 and 0", seen.size(), gaps);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_set = 0, n_busy_set = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(i < 10, 8'($urandom), 0, 2'd0, 8'h00, i == 0 || i == 2);
            n_checks++;
            if (obs() !== expv()) $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
            if (bus.s_set_coeffs) begin
                n_set++;
                n_busy_set += int'(bus.busy);
            end
        end
        n_checks++;
        if (n_set !== 6 || n_busy_set !== 6 || bus.overflow !== 1'b1)
            $display("FAIL back_to_back_summary: got set=%0d busy=%0d ovf=%b expected 6 6 1", n_set, n_busy_set, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        logic [7:0] caps[$];
        for (int i = 0; i < 11; i++) begin
            drive_cycle(0, 8'h00, i == 1 || i == 5, (i == 1) ? 2'd1 : 2'd3, (i == 1) ? 8'h55 : 8'h99,
                        i == 0 || i == 6);
            n_checks++;
            if (obs() !== expv()) $display("FAIL snapshot[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
            if (bus.s_set_coeffs) caps.push_back(bus.x_n);
        end
        n_checks++;
        if (caps.size() !== 6) $display("FAIL snapshot_len: got %0d expected 6", caps.size());
        else begin
            n_pass++;
            n_checks++;
            if (caps[1] !== 8'hFB || caps[4] !== 8'h55 || caps[5] !== 8'h1B)
                $display("FAIL snapshot_vals: got %h %h %h expected fb 55 1b", caps[1], caps[4], caps[5]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(0, 8'h00, 0, 2'd0, 8'h00, 1);
        drive_cycle(1, 8'h21, 0, 2'd0, 8'h00, 0);
        drive_cycle(1, 8'h22, 0, 2'd0, 8'h00, 0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 13'h0) $display("FAIL async_reset: got %h expected %h", obs(), 13'h0);
        else n_pass++;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, 8'h42, 0, 2'd0, 8'h00, 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL after_reset[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0),
                        2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 15) == 0));
            n_checks++;
            if (obs() !== expv()) $display("FAIL random[%0d]: got %h expected %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_idle_load();
        test_load_during_stream();
        test_back_to_back();
        test_snapshot();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_coeff_sequencer.md
Name: fir_coeff_sequencer

Overview:
- Drives the adaptive FIR's input interface (x_n, s_axis_fir_tvalid, s_set_coeffs) as its upstream master.
- Holds a shadow bank of coefficients written by the host. On request, it plays the coefficients into the FIR over NUM_COEFFS consecutive cycles with s_set_coeffs high.
- Samples that arrive during a coefficient load are buffered in a small FIFO and replayed afterwards, so no sample is lost and sample order is preserved.

Parameters:
- DATA_W, 8, width of samples and coefficients (signed).
- NUM_COEFFS, 3, number of coefficient words per load burst; also the number of shadow registers.
- FIFO_DEPTH, 4, sample buffer depth; power of two, at least NUM_COEFFS+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_W  signed input sample.
- sample_valid  in  1  sample_in valid this cycle.
- coeff_wr_en  in  1  write coeff_wr_data into shadow register coeff_wr_addr.
- coeff_wr_addr  in  clog2(NUM_COEFFS)  shadow register index; out-of-range writes are ignored.
- coeff_wr_data  in  DATA_W  coefficient value.
- load_req  in  1  single-cycle request to load the shadow bank into the FIR.
- x_n  out  DATA_W  data to FIR: a sample or a coefficient.
- s_axis_fir_tvalid  out  1  x_n carries a valid sample.
- s_set_coeffs  out  1  x_n carries a coefficient.
- busy  out  1  high in LOAD state or while a load is pending.
- load_done  out  1  one-cycle pulse in the cycle after the last coefficient cycle.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - Shadow registers are 0, the FIFO is empty, the pending flag is clear, and the FSM is in STREAM.
- All outputs are registered. s_axis_fir_tvalid and s_set_coeffs are never high in the same cycle.
- Shadow writes take effect at the clock edge where coeff_wr_en=1. The writes themselves are accepted in any state.
- STREAM state, per cycle:
  - FIFO empty and sample_valid=1: x_n<=sample_in, tvalid<=1 on the next edge. Latency is 1 cycle.
  - FIFO non-empty: pop the head into x_n with tvalid<=1. If sample_valid=1, push sample_in in the same cycle, so the occupancy is unchanged.
  - FIFO empty and sample_valid=0: tvalid<=0, and x_n holds its last value.
- STREAM to LOAD: when load_req=1 or the pending flag is set.
  - At that edge the shadow bank is snapshot into a burst register and the burst counter is cleared.
  - Shadow writes made during LOAD affect only the next load.
- LOAD state, for cycles k=0..NUM_COEFFS-1 after entry:
  - x_n=snapshot[k], s_set_coeffs=1, tvalid=0.
  - Incoming valid samples are pushed into the FIFO.
  - If the FIFO is full, the sample is dropped and overflow<=1. overflow is cleared only by reset.
- LOAD to STREAM: after the NUM_COEFFS-th coefficient cycle.
  - load_done pulses in the first STREAM cycle.
  - FIFO replay starts in that same cycle.
- load_req while in LOAD sets the pending flag; only one request is held. A second load starts immediately after the current one, with no STREAM cycle in between. In that case load_done pulses in the first cycle of the new LOAD.
- load_req in the same cycle as coeff_wr_en: the snapshot takes the newly written value.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits; full and empty are decided by comparing the pointer MSBs.
- busy = (state==LOAD) | pending.
- A reset asserted mid-load aborts the burst. All outputs drop to 0 asynchronously and the FIFO contents are discarded.

Test Plan:
- Reset then stream: write nothing, feed samples 1,2,3 with valid on consecutive cycles → x_n=1,2,3 with tvalid=1 one cycle later each; s_set_coeffs=0; overflow=0.
- Coefficient load while idle: write coeff[0..2]=0x07, 0xFB, 0x1B, pulse load_req with sample_valid=0 → 3 cycles of s_set_coeffs=1 with x_n=0x07, 0xFB, 0x1B; tvalid=0; then load_done=1 for 1 cycle.
- Load during a continuous stream: samples 10,11,12,… every cycle, load_req at the cycle sample 12 is presented → after 12, three coefficient cycles, then 13,14,15,… in order with none missing; the steady-state latency increases by 3 cycles.
- Back-to-back loads: a second load_req during LOAD → 6 consecutive s_set_coeffs cycles, busy high throughout; with samples arriving continuously, 4 are buffered and the excess is dropped with overflow=1 (sticky).
- Snapshot isolation: write coeff[1]=0x55 during LOAD cycle 0 → the current burst emits the old coeff[1]; the next load emits 0x55. An out-of-range address write (addr=3) changes nothing.
- Asynchronous reset in LOAD cycle 1 → all outputs 0 immediately; after release, a fresh sample passes through with 1-cycle latency and the FIFO is empty.
